lcd_menu_ctrl: RTL and testbench

LCD_MENU_CTRL -- requirements
Module: lcd_menu_ctrl

---
 rtl/lcd_menu_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_lcd_menu_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_menu_ctrl.sv
`timescale 1ns/1ps
// lcd_menu_ctrl
// Two-level LED menu shown on an HD44780 character LCD (8-bit bus, write-only).
// Four buttons move a cursor over N_LEDS entries (BROWSE), open one entry
// (DETAIL), toggle its LED and return. Every accepted action redraws the screen.
//
// Ports
//   Clock       system clock, everything on the rising edge
//   Reset_n     synchronous active-low reset
//   sobe/desce  up/down buttons (asynchronous, active high)
//   selec/volta select/back buttons (asynchronous, active high)
//   LCD_RS      0 = command byte, 1 = character byte
//   LCD_EN      write strobe
//   LCD_RW      always 0
//   LCD_DATA    byte on the LCD bus
//   LED         LED state, bit k = LED k+1
//   busy        high while the power-up/init or a redraw is in progress
//   seq_state   debug: byte-writer state (see seq_t)
//   menu_state  debug: 0 = BROWSE, 1 = DETAIL
module lcd_menu_ctrl #(
    parameter int N_LEDS         = 5,
    parameter int POWERUP_CYCLES = 750000,
    parameter int EN_CYCLES      = 12,
    parameter int WAIT_CYCLES    = 2000,
    parameter int CLR_CYCLES     = 80000
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              sobe,
    input  logic              desce,
    input  logic              selec,
    input  logic              volta,
    output logic              LCD_RS,
    output logic              LCD_EN,
    output logic              LCD_RW,
    output logic [7:0]        LCD_DATA,
    output logic [N_LEDS-1:0] LED,
    output logic              busy,
    output logic [2:0]        seq_state,
    output logic              menu_state
);
    // One down-counter-free timer serves every phase, so it is sized by the longest one.
    localparam int MAX_A   = (POWERUP_CYCLES > EN_CYCLES) ? POWERUP_CYCLES : EN_CYCLES;
    localparam int MAX_B   = (WAIT_CYCLES > CLR_CYCLES) ? WAIT_CYCLES : CLR_CYCLES;
    localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam int IW      = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;

    // Byte script: 0..3 init commands, 4..8 clear + "LEDn",
    // 9 second-line command, 10.. "ACESO"/"APAGADO". A redraw starts at 4.
    localparam logic [4:0] P_REDRAW     = 5'd4;
    localparam logic [4:0] P_LAST_BROWS = 5'd8;
    localparam logic [4:0] P_LAST_ON    = 5'd14;
    localparam logic [4:0] P_LAST_OFF   = 5'd16;

    // Button vector order
    localparam int B_VOLTA = 3;
    localparam int B_SELEC = 2;
    localparam int B_SOBE  = 1;
    localparam int B_DESCE = 0;

    typedef enum logic [2:0] {
        S_POWERUP = 3'd0,
        S_SETUP   = 3'd1,
        S_EN      = 3'd2,
        S_WAIT    = 3'd3,
        S_IDLE    = 3'd4
    } seq_t;

    seq_t              seq_q, seq_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [4:0]        ptr_q, ptr_d;
    logic              detail_q, detail_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [N_LEDS-1:0] led_q, led_d;
    logic [3:0]        sync1_q, sync2_q, sync3_q;
    logic [3:0]        ev;

    logic [7:0]        cur_byte;
    logic              cur_rs;
    logic              led_on;
    logic [4:0]        last_ptr;
    logic [CW-1:0]     wait_last;

    // Rising edge of the second synchroniser stage; sync3 is just the delayed copy.
    assign ev = sync2_q & ~sync3_q;

    assign led_on   = led_q[idx_q];
    assign last_ptr = !detail_q ? P_LAST_BROWS : (led_on ? P_LAST_ON : P_LAST_OFF);

    // Byte at the current script position.
    always_comb begin
        cur_byte = 8'h00;
        cur_rs   = 1'b1;
        case (ptr_q)
            5'd0:    begin cur_byte = 8'h38; cur_rs = 1'b0; end
            5'd1:    begin cur_byte = 8'h0C; cur_rs = 1'b0; end
            5'd2:    begin cur_byte = 8'h06; cur_rs = 1'b0; end
            5'd3:    begin cur_byte = 8'h01; cur_rs = 1'b0; end
            5'd4:    begin cur_byte = 8'h01; cur_rs = 1'b0; end
            5'd5:    cur_byte = 8'h4C;
            5'd6:    cur_byte = 8'h45;
            5'd7:    cur_byte = 8'h44;
            5'd8:    cur_byte = 8'h31 + 8'(idx_q);
            5'd9:    begin cur_byte = 8'hC0; cur_rs = 1'b0; end
            5'd10:   cur_byte = 8'h41;
            5'd11:   cur_byte = led_on ? 8'h43 : 8'h50;
            5'd12:   cur_byte = led_on ? 8'h45 : 8'h41;
            5'd13:   cur_byte = led_on ? 8'h53 : 8'h47;
            5'd14:   cur_byte = led_on ? 8'h4F : 8'h41;
            5'd15:   cur_byte = 8'h44;
            5'd16:   cur_byte = 8'h4F;
            default: cur_byte = 8'h00;
        endcase
    end

    // Clear/home need the long settle time.
    assign wait_last = (!cur_rs && (cur_byte == 8'h01 || cur_byte == 8'h02))
                       ? CW'(CLR_CYCLES - 1) : CW'(WAIT_CYCLES - 1);

    // State register
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            seq_q    <= S_POWERUP;
            cnt_q    <= '0;
            ptr_q    <= '0;
            detail_q <= 1'b0;
            idx_q    <= '0;
            led_q    <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
            sync3_q  <= '0;
        end else begin
            seq_q    <= seq_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            detail_q <= detail_d;
            idx_q    <= idx_d;
            led_q    <= led_d;
            sync1_q  <= {volta, selec, sobe, desce};
            sync2_q  <= sync1_q;
            sync3_q  <= sync2_q;
        end
    end

    // Next state: byte writer plus menu. Events only matter in S_IDLE, so
    // anything arriving during init or a redraw is dropped.
    always_comb begin
        logic redraw;
        seq_d    = seq_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        detail_d = detail_q;
        idx_d    = idx_q;
        led_d    = led_q;
        redraw   = 1'b0;
        case (seq_q)
            S_POWERUP: begin
                if (cnt_q == CW'(POWERUP_CYCLES - 1)) begin
                    seq_d = S_SETUP;
                    cnt_d = '0;
                    ptr_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SETUP: begin
                seq_d = S_EN;
                cnt_d = '0;
            end
            S_EN: begin
                if (cnt_q == CW'(EN_CYCLES - 1)) begin
                    seq_d = S_WAIT;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_q == wait_last) begin
                    cnt_d = '0;
                    if (ptr_q == last_ptr) begin
                        seq_d = S_IDLE;
                    end else begin
                        ptr_d = ptr_q + 5'd1;
                        seq_d = S_SETUP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                // Highest-priority event wins even when it turns out to be ignored.
                if (ev[B_VOLTA]) begin
                    if (detail_q) begin
                        detail_d = 1'b0;
                        redraw   = 1'b1;
                    end
                end else if (ev[B_SELEC]) begin
                    if (!detail_q) detail_d = 1'b1;
                    else           led_d[idx_q] = ~led_q[idx_q];
                    redraw = 1'b1;
                end else if (ev[B_SOBE]) begin
                    if (!detail_q) begin
                        idx_d  = (idx_q == IW'(N_LEDS - 1)) ? '0 : idx_q + 1'b1;
                        redraw = 1'b1;
                    end
                end else if (ev[B_DESCE]) begin
                    if (!detail_q) begin
                        idx_d  = (idx_q == '0) ? IW'(N_LEDS - 1) : idx_q - 1'b1;
                        redraw = 1'b1;
                    end
                end
                if (redraw) begin
                    seq_d = S_SETUP;
                    ptr_d = P_REDRAW;
                    cnt_d = '0;
                end
            end
            default: seq_d = S_POWERUP;
        endcase
    end

    // Outputs: RS/DATA stay valid from setup through the post-write wait.
    always_comb begin
        LCD_RW   = 1'b0;
        LCD_EN   = 1'b0;
        LCD_RS   = 1'b0;
        LCD_DATA = 8'h00;
        busy     = 1'b1;
        case (seq_q)
            S_SETUP, S_WAIT: begin
                LCD_RS   = cur_rs;
                LCD_DATA = cur_byte;
            end
            S_EN: begin
                LCD_RS   = cur_rs;
                LCD_DATA = cur_byte;
                LCD_EN   = 1'b1;
            end
            S_IDLE:  busy = 1'b0;
            default: busy = 1'b1;
        endcase
    end

    assign LED        = led_q;
    assign seq_state  = seq_q;
    assign menu_state = detail_q;

endmodule

// File: tb/tb_lcd_menu_ctrl.sv
`timescale 1ns/1ps
// Directed bench for lcd_menu_ctrl with short timing parameters.
// Every LCD byte is captured with its RS, setup value, EN width, held value
// and the number of EN-low samples before it; the expected screens are built
// from the menu behaviour (bytes, RS, wait lengths) and compared per scenario.
module tb_lcd_menu_ctrl;
    localparam int N_LEDS = 5;
    localparam int PU     = 10;
    localparam int ENC    = 2;
    localparam int WT     = 4;
    localparam int CLR    = 8;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              sobe = 1'b0, desce = 1'b0, selec = 1'b0, volta = 1'b0;
    logic              lcd_rs, lcd_en, lcd_rw;
    logic [7:0]        lcd_data;
    logic [N_LEDS-1:0] led;
    logic              busy;
    logic [2:0]        seq_state;
    logic              menu_state;

    int total = 0;
    int bad   = 0;

    // expected screens
    logic [7:0] exp_q[$];
    logic       exp_rs_q[$];
    int         exp_gap_q[$];
    int         exp_idle_q[$];
    // captured bytes
    logic [7:0] cap_d_q[$], cap_setup_q[$], cap_hold_q[$];
    logic       cap_rs_q[$];
    int         cap_en_q[$], cap_gap_q[$], idle_q[$];

    lcd_menu_ctrl #(
        .N_LEDS(N_LEDS), .POWERUP_CYCLES(PU), .EN_CYCLES(ENC),
        .WAIT_CYCLES(WT), .CLR_CYCLES(CLR)
    ) dut (
        .Clock(clk), .Reset_n(reset_n),
        .sobe(sobe), .desce(desce), .selec(selec), .volta(volta),
        .LCD_RS(lcd_rs), .LCD_EN(lcd_en), .LCD_RW(lcd_rw), .LCD_DATA(lcd_data),
        .LED(led), .busy(busy), .seq_state(seq_state), .menu_state(menu_state)
    );

    always #5 clk = ~clk;

    function automatic void clear_model();
        exp_q.delete(); exp_rs_q.delete(); exp_gap_q.delete(); exp_idle_q.delete();
        cap_d_q.delete(); cap_setup_q.delete(); cap_hold_q.delete();
        cap_rs_q.delete(); cap_en_q.delete(); cap_gap_q.delete(); idle_q.delete();
    endfunction

    // gap = -2: derive from previous byte (wait + setup), -1: not checked
    function automatic void push_byte(input logic [7:0] b, input logic rs, input int gap);
        int g = gap;
        if (g == -2)
            g = ((exp_q[$] == 8'h01 || exp_q[$] == 8'h02) && exp_rs_q[$] == 1'b0) ? CLR + 1 : WT + 1;
        exp_q.push_back(b);
        exp_rs_q.push_back(rs);
        exp_gap_q.push_back(g);
    endfunction

    function automatic void push_screen(input int num, input bit detail, input bit on, input int first_gap);
        push_byte(8'h01, 1'b0, first_gap);
        push_byte("L", 1'b1, -2);
        push_byte("E", 1'b1, -2);
        push_byte("D", 1'b1, -2);
        push_byte(8'h30 + 8'(num), 1'b1, -2);
        if (detail) begin
            push_byte(8'hC0, 1'b0, -2);
            if (on) begin
                push_byte("A", 1'b1, -2); push_byte("C", 1'b1, -2); push_byte("E", 1'b1, -2);
                push_byte("S", 1'b1, -2); push_byte("O", 1'b1, -2);
            end else begin
                push_byte("A", 1'b1, -2); push_byte("P", 1'b1, -2); push_byte("A", 1'b1, -2);
                push_byte("G", 1'b1, -2); push_byte("A", 1'b1, -2); push_byte("D", 1'b1, -2);
                push_byte("O", 1'b1, -2);
            end
        end
        exp_idle_q.push_back(WT);
    endfunction

    // Called at a negedge; the current sample is counted.
    task automatic capture_one();
        int         lows = 0;
        int         highs = 0;
        logic [7:0] setup_d = 8'hxx;
        logic [7:0] d;
        logic       rs;
        while (lcd_en !== 1'b1 && lows < 300) begin
            setup_d = lcd_data;
            lows++;
            @(negedge clk);
        end
        d  = lcd_data;
        rs = lcd_rs;
        while (lcd_en === 1'b1 && highs < 300) begin
            highs++;
            @(negedge clk);
        end
        cap_d_q.push_back(d);
        cap_rs_q.push_back(rs);
        cap_setup_q.push_back(setup_d);
        cap_hold_q.push_back(lcd_data);
        cap_en_q.push_back(highs);
        cap_gap_q.push_back(lows);
    endtask

    // Capture until the expected list is covered, then count busy samples left.
    task automatic grab();
        int n = 0;
        while (cap_d_q.size() < exp_q.size()) capture_one();
        while (busy === 1'b1 && n < 300) begin
            n++;
            @(negedge clk);
        end
        idle_q.push_back(n);
    endtask

    // b = {volta, selec, sobe, desce}; called and returns at a negedge
    task automatic press(input logic [3:0] b);
        {volta, selec, sobe, desce} = b;
        @(negedge clk);
        @(negedge clk);
        {volta, selec, sobe, desce} = 4'b0000;
    endtask

    task automatic quiet(input int cycles, output int en_hi, output int busy_hi);
        en_hi = 0;
        busy_hi = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (lcd_en !== 1'b0) en_hi++;
            if (busy !== 1'b0) busy_hi++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({lcd_rs, lcd_en, lcd_rw, lcd_data} !== 11'h000) begin
            bad++;
            $display("FAIL reset_lcd: got rs=%b en=%b rw=%b data=%h, want 0 0 0 00", lcd_rs, lcd_en, lcd_rw, lcd_data);
        end
        total++;
        if (led !== 5'b00000 || busy !== 1'b1 || menu_state !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got led=%b busy=%b menu=%b, want 00000 1 0", led, busy, menu_state);
        end
    endtask

    task automatic test_init();
        clear_model();
        push_byte(8'h38, 1'b0, PU + 1);   // power-up cycles plus the setup cycle
        push_byte(8'h0C, 1'b0, -2);
        push_byte(8'h06, 1'b0, -2);
        push_byte(8'h01, 1'b0, -2);
        push_screen(1, 1'b0, 1'b0, -2);
        reset_n = 1'b1;
        grab();
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (cap_d_q[i] !== exp_q[i] || cap_rs_q[i] !== exp_rs_q[i] || cap_setup_q[i] !== exp_q[i] ||
                cap_hold_q[i] !== exp_q[i] || cap_en_q[i] != ENC || (exp_gap_q[i] >= 0 && cap_gap_q[i] != exp_gap_q[i])) begin
                bad++;
                $display("FAIL init byte %0d: got data=%h rs=%b setup=%h hold=%h en=%0d gap=%0d, want data=%h rs=%b en=%0d gap=%0d",
                         i, cap_d_q[i], cap_rs_q[i], cap_setup_q[i], cap_hold_q[i], cap_en_q[i], cap_gap_q[i],
                         exp_q[i], exp_rs_q[i], ENC, exp_gap_q[i]);
            end
        end
        total++;
        if (idle_q[0] != exp_idle_q[0] || busy !== 1'b0 || led !== 5'b00000 || lcd_rw !== 1'b0) begin
            bad++;
            $display("FAIL init_end: got busy_tail=%0d busy=%b led=%b rw=%b, want %0d 0 00000 0", idle_q[0], busy, led, lcd_rw, exp_idle_q[0]);
        end
    endtask

    task automatic test_wrap();
        clear_model();
        press(4'b0001);                     // desce at idx 0 -> idx 4
        @(negedge clk);
        push_screen(5, 1'b0, 1'b0, -1);
        grab();
        press(4'b0010);                     // sobe at idx 4 -> idx 0
        @(negedge clk);
        push_screen(1, 1'b0, 1'b0, -1);
        grab();
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (cap_d_q[i] !== exp_q[i] || cap_rs_q[i] !== exp_rs_q[i] || cap_setup_q[i] !== exp_q[i] ||
                cap_hold_q[i] !== exp_q[i] || cap_en_q[i] != ENC || (exp_gap_q[i] >= 0 && cap_gap_q[i] != exp_gap_q[i])) begin
                bad++;
                $display("FAIL wrap byte %0d: got data=%h rs=%b setup=%h hold=%h en=%0d gap=%0d, want data=%h rs=%b en=%0d gap=%0d",
                         i, cap_d_q[i], cap_rs_q[i], cap_setup_q[i], cap_hold_q[i], cap_en_q[i], cap_gap_q[i],
                         exp_q[i], exp_rs_q[i], ENC, exp_gap_q[i]);
            end
        end
        for (int i = 0; i < exp_idle_q.size(); i++) begin
            total++;
            if (idle_q[i] != exp_idle_q[i]) begin
                bad++;
                $display("FAIL wrap busy_tail %0d: got %0d, want %0d", i, idle_q[i], exp_idle_q[i]);
            end
        end
    endtask

    task automatic test_detail();
        clear_model();
        press(4'b0010); @(negedge clk); push_screen(2, 1'b0, 1'b0, -1); grab();
        press(4'b0010); @(negedge clk); push_screen(3, 1'b0, 1'b0, -1); grab();
        press(4'b0100);                     // selec: enter DETAIL, LED unchanged
        @(negedge clk);
        total++;
        if (menu_state !== 1'b1 || led !== 5'b00000 || busy !== 1'b1) begin
            bad++;
            $display("FAIL detail_enter: got menu=%b led=%b busy=%b, want 1 00000 1", menu_state, led, busy);
        end
        push_screen(3, 1'b1, 1'b0, -1); grab();
        press(4'b0100);                     // selec: toggle LED3, visible as the redraw starts
        @(negedge clk);
        total++;
        if (led !== 5'b00100 || busy !== 1'b1) begin
            bad++;
            $display("FAIL detail_toggle: got led=%b busy=%b, want 00100 1", led, busy);
        end
        push_screen(3, 1'b1, 1'b1, -1); grab();
        press(4'b1000);                     // volta: back to BROWSE
        @(negedge clk);
        push_screen(3, 1'b0, 1'b0, -1); grab();
        total++;
        if (menu_state !== 1'b0 || led !== 5'b00100) begin
            bad++;
            $display("FAIL detail_back: got menu=%b led=%b, want 0 00100", menu_state, led);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (cap_d_q[i] !== exp_q[i] || cap_rs_q[i] !== exp_rs_q[i] || cap_setup_q[i] !== exp_q[i] ||
                cap_hold_q[i] !== exp_q[i] || cap_en_q[i] != ENC || (exp_gap_q[i] >= 0 && cap_gap_q[i] != exp_gap_q[i])) begin
                bad++;
                $display("FAIL detail byte %0d: got data=%h rs=%b setup=%h hold=%h en=%0d gap=%0d, want data=%h rs=%b en=%0d gap=%0d",
                         i, cap_d_q[i], cap_rs_q[i], cap_setup_q[i], cap_hold_q[i], cap_en_q[i], cap_gap_q[i],
                         exp_q[i], exp_rs_q[i], ENC, exp_gap_q[i]);
            end
        end
        for (int i = 0; i < exp_idle_q.size(); i++) begin
            total++;
            if (idle_q[i] != exp_idle_q[i]) begin
                bad++;
                $display("FAIL detail busy_tail %0d: got %0d, want %0d", i, idle_q[i], exp_idle_q[i]);
            end
        end
    endtask

    task automatic test_priority();
        int en_hi, busy_hi;
        clear_model();
        press(4'b1000);                     // volta in BROWSE: ignored
        quiet(30, en_hi, busy_hi);
        total++;
        if (en_hi != 0 || busy_hi != 0) begin
            bad++;
            $display("FAIL volta_browse: got en_samples=%0d busy_samples=%0d, want 0 0", en_hi, busy_hi);
        end
        press(4'b0110);                     // sobe + selec together: selec wins
        @(negedge clk);
        total++;
        if (menu_state !== 1'b1) begin
            bad++;
            $display("FAIL priority_state: got menu=%b, want 1", menu_state);
        end
        push_screen(3, 1'b1, 1'b1, -1); grab();
        press(4'b0010);                     // sobe in DETAIL: ignored
        quiet(30, en_hi, busy_hi);
        total++;
        if (en_hi != 0 || busy_hi != 0) begin
            bad++;
            $display("FAIL sobe_detail: got en_samples=%0d busy_samples=%0d, want 0 0", en_hi, busy_hi);
        end
        press(4'b0001);                     // desce in DETAIL: ignored
        quiet(30, en_hi, busy_hi);
        total++;
        if (en_hi != 0 || busy_hi != 0) begin
            bad++;
            $display("FAIL desce_detail: got en_samples=%0d busy_samples=%0d, want 0 0", en_hi, busy_hi);
        end
        press(4'b1000);
        @(negedge clk);
        push_screen(3, 1'b0, 1'b0, -1); grab();
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (cap_d_q[i] !== exp_q[i] || cap_rs_q[i] !== exp_rs_q[i] || cap_setup_q[i] !== exp_q[i] ||
                cap_hold_q[i] !== exp_q[i] || cap_en_q[i] != ENC || (exp_gap_q[i] >= 0 && cap_gap_q[i] != exp_gap_q[i])) begin
                bad++;
                $display("FAIL priority byte %0d: got data=%h rs=%b setup=%h hold=%h en=%0d gap=%0d, want data=%h rs=%b en=%0d gap=%0d",
                         i, cap_d_q[i], cap_rs_q[i], cap_setup_q[i], cap_hold_q[i], cap_en_q[i], cap_gap_q[i],
                         exp_q[i], exp_rs_q[i], ENC, exp_gap_q[i]);
            end
        end
    endtask

    task automatic test_busy_drop();
        int en_hi, busy_hi;
        clear_model();
        press(4'b0001);                     // desce: idx 2 -> 1
        @(negedge clk);
        push_screen(2, 1'b0, 1'b0, -1);
        fork
            grab();
            begin
                repeat (8) @(negedge clk);
                press(4'b0010);             // sobe while busy: dropped
            end
        join
        quiet(40, en_hi, busy_hi);
        total++;
        if (en_hi != 0 || busy_hi != 0) begin
            bad++;
            $display("FAIL busy_drop_quiet: got en_samples=%0d busy_samples=%0d, want 0 0", en_hi, busy_hi);
        end
        press(4'b0010);                     // idx still 1, so this shows LED3
        @(negedge clk);
        push_screen(3, 1'b0, 1'b0, -1); grab();
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (cap_d_q[i] !== exp_q[i] || cap_rs_q[i] !== exp_rs_q[i] || cap_setup_q[i] !== exp_q[i] ||
                cap_hold_q[i] !== exp_q[i] || cap_en_q[i] != ENC || (exp_gap_q[i] >= 0 && cap_gap_q[i] != exp_gap_q[i])) begin
                bad++;
                $display("FAIL busy_drop byte %0d: got data=%h rs=%b setup=%h hold=%h en=%0d gap=%0d, want data=%h rs=%b en=%0d gap=%0d",
                         i, cap_d_q[i], cap_rs_q[i], cap_setup_q[i], cap_hold_q[i], cap_en_q[i], cap_gap_q[i],
                         exp_q[i], exp_rs_q[i], ENC, exp_gap_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        press(4'b0010);                     // start a redraw, then reset during EN
        while (lcd_en !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        total++;
        if (lcd_en !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_wait: got en=%b after %0d cycles, want 1", lcd_en, n);
        end
        reset_n = 1'b0;
        @(negedge clk);
        total++;
        if (lcd_en !== 1'b0 || led !== 5'b00000 || busy !== 1'b1 || lcd_data !== 8'h00 || menu_state !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_state: got en=%b led=%b busy=%b data=%h menu=%b, want 0 00000 1 00 0",
                     lcd_en, led, busy, lcd_data, menu_state);
        end
        @(negedge clk);
        test_init();
    endtask

    initial begin
        test_reset();
        test_init();
        test_wrap();
        test_detail();
        test_priority();
        test_busy_drop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
